// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter for the single register-file write port. It also
//   sequences a bulk clear that writes zero to every register from 1 to
//   all-ones. Register 0 is hardwired to zero and is never written.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   req        per-requester write request (bit i = requester i)
//   req_addr   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   packed data, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot combinational grant; transfer when req[i] & gnt[i]
//   clear_req  starts the bulk clear (sampled in IDLE only)
//   clear_busy high in every clear write cycle
//   clear_done one-cycle pulse alongside the final clear write
//   wr_en      registered write enable
//   wr_addr    registered write address
//   wr_data    registered write data
module regfile_write_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      clear_req,
   output logic                      clear_busy,
   output logic                      clear_done,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t             state;
   state_t             state_next;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   ptr_next;
   logic [PTR_W-1:0]   idx;
   logic [PTR_W-1:0]   win;
   logic               found;
   logic [ADDR_W-1:0]  cnt;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      idx        = '0;
      win        = '0;
      found      = 1'b0;
      win_addr   = '0;
      win_data   = '0;
      gnt        = '0;
      case (state)
         IDLE: begin
            // A pending clear suppresses arbitration so the clear wins the edge.
            if (clear_req) begin
               state_next = CLEAR;
            end else begin
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
                  if (!found && req[idx]) begin
                     found = 1'b1;
                     win   = idx;
                  end
               end
            end
         end
         CLEAR: begin
            // Leave CLEAR on the final write so arbitration is live during
            // the clear_done cycle.
            if (cnt == '1) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (found && rst) gnt = NUM_REQ'(1) << win;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (found && win == PTR_W'(i)) begin
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
            win_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      ptr_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= '0;
         cnt        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               clear_busy <= 1'b0;
               clear_done <= 1'b0;
               if (clear_req) begin
                  wr_en <= 1'b0;
                  cnt   <= ADDR_W'(1);
               end else if (found) begin
                  // Address 0 is consumed without asserting the write enable.
                  wr_en   <= |win_addr;
                  wr_addr <= win_addr;
                  wr_data <= win_data;
                  ptr     <= ptr_next;
               end else begin
                  wr_en <= 1'b0;
               end
            end
            CLEAR: begin
               wr_en      <= 1'b1;
               wr_addr    <= cnt;
               wr_data    <= '0;
               clear_busy <= 1'b1;
               clear_done <= (cnt == '1);
               cnt        <= cnt + ADDR_W'(1);
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed self-checking bench for regfile_write_arbiter with default
//   parameters (4 requesters, 6-bit address, 32-bit data).
module tb_regfile_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 32;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      clear_req;
   logic                      clear_busy;
   logic                      clear_done;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [DATA_W-1:0]         wr_data;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .gnt       (gnt),
      .clear_req (clear_req),
      .clear_busy(clear_busy),
      .clear_done(clear_done),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      req       = '0;
      clear_req = 1'b0;
      #1;
      step();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #2;
      req = 4'b1111;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
      checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
      checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
      checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", clear_busy); end
      checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", clear_done); end
      req = '0;
      step();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_single();
      set_slot(0, 6'd5, 32'hDEADBEEF);
      req = 4'b0001;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
      step();
      req = '0;
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b expected 1", wr_en); end
      checks++; if (wr_addr !== 6'd5) begin errors++; $display("FAIL single_wr_addr: got %0d expected 5", wr_addr); end
      checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_data: got %h expected deadbeef", wr_data); end
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_idle_wr_en: got %b expected 0", wr_en); end
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_gnt;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_slot(i, ADDR_W'(10 + i), 32'hA5A5_0000 + DATA_W'(i));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         #1;
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_gnt); end
         step();
         checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en[%0d]: got %b expected 1", k, wr_en); end
         checks++; if (wr_addr !== ADDR_W'(10 + k % 4)) begin errors++; $display("FAIL rr_wr_addr[%0d]: got %0d expected %0d", k, wr_addr, 10 + k % 4); end
         checks++; if (wr_data !== 32'hA5A5_0000 + DATA_W'(k % 4)) begin errors++; $display("FAIL rr_wr_data[%0d]: got %h expected %h", k, wr_data, 32'hA5A5_0000 + DATA_W'(k % 4)); end
      end
      req = '0;
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rr_idle_wr_en: got %b expected 0", wr_en); end
      checks++; if (wr_addr !== 6'd13) begin errors++; $display("FAIL rr_hold_addr: got %0d expected 13", wr_addr); end
      checks++; if (wr_data !== 32'hA5A5_0003) begin errors++; $display("FAIL rr_hold_data: got %h expected a5a50003", wr_data); end
   endtask

   task automatic test_addr_zero();
      set_slot(2, 6'd0, 32'h1234_5678);
      req = 4'b0100;
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL az_gnt: got %b expected 0100", gnt); end
      step();
      req = '0;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL az_wr_en: got %b expected 0", wr_en); end
      checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL az_wr_addr: got %0d expected 0", wr_addr); end
      req = 4'b1111;
      #1;
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL az_ptr_gnt: got %b expected 1000", gnt); end
      req = '0;
      #1;
   endtask

   task automatic test_clear();
      do_reset();
      set_slot(0, 6'd7, 32'hC0DE_0000);
      set_slot(1, 6'd8, 32'hC0DE_0001);
      req       = 4'b0011;
      clear_req = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL clr_gnt_prio: got %b expected 0000", gnt); end
      step();
      clear_req = 1'b0;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL clr_e0_wr_en: got %b expected 0", wr_en); end
      checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clr_e0_busy: got %b expected 0", clear_busy); end
      for (int a = 1; a <= 63; a++) begin
         step();
         checks++;
         if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(a) || wr_data !== 32'd0 || clear_busy !== 1'b1 || clear_done !== (a == 63)) begin
            errors++;
            $display("FAIL clr_write[%0d]: got en=%b addr=%0d data=%h busy=%b done=%b expected en=1 addr=%0d data=0 busy=1 done=%0d",
                     a, wr_en, wr_addr, wr_data, clear_busy, clear_done, a, a == 63);
         end
         checks++;
         if (gnt !== ((a == 63) ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL clr_gnt[%0d]: got %b expected %b", a, gnt, (a == 63) ? 4'b0001 : 4'b0000);
         end
      end
      step();
      req = '0;
      checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd7 || wr_data !== 32'hC0DE_0000) begin errors++; $display("FAIL clr_after_write: got en=%b addr=%0d data=%h expected en=1 addr=7 data=c0de0000", wr_en, wr_addr, wr_data); end
      checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL clr_after_flags: got busy=%b done=%b expected 0 0", clear_busy, clear_done); end
   endtask

   task automatic test_clear_retrigger();
      int busy_cycles = 0;
      int done_cycles = 0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (clear_busy === 1'b1) busy_cycles++;
         else if (busy_cycles > 0) break;
         if (clear_done === 1'b1) done_cycles++;
         if (n == 5) clear_req = 1'b1;
         if (n == 6) clear_req = 1'b0;
      end
      checks++; if (busy_cycles != 63) begin errors++; $display("FAIL retrig_len: got %0d expected 63", busy_cycles); end
      checks++; if (done_cycles != 1) begin errors++; $display("FAIL retrig_done_count: got %0d expected 1", done_cycles); end
      step();
      checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL retrig_no_restart: got %b expected 0", clear_busy); end
   endtask

   task automatic test_reset_during_clear();
      bit seen = 1'b0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         step();
         if (wr_addr === 6'd20 && clear_busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rdc_wait_addr20: got timeout expected wr_addr 20"); end
      rst = 1'b0;
      req = 4'b0010;
      #1;
      checks++; if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL rdc_async_wr: got en=%b addr=%0d data=%h expected 0 0 0", wr_en, wr_addr, wr_data); end
      checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL rdc_async_flags: got busy=%b done=%b expected 0 0", clear_busy, clear_done); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rdc_gnt_in_reset: got %b expected 0000", gnt); end
      step();
      step();
      checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rdc_no_done: got %b expected 0", clear_done); end
      set_slot(1, 6'd33, 32'h0BAD_F00D);
      rst = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rdc_release_gnt: got %b expected 0010", gnt); end
      step();
      req = '0;
      checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd33 || wr_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL rdc_release_write: got en=%b addr=%0d data=%h expected 1 33 0badf00d", wr_en, wr_addr, wr_data); end
      checks++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL rdc_release_flags: got busy=%b done=%b expected 0 0", clear_busy, clear_done); end
   endtask

   initial begin
      rst       = 1'b0;
      req       = '0;
      clear_req = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_addr_zero();
      test_clear();
      test_clear_retrigger();
      test_reset_during_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among NUM_REQ requesters (ALU writeback, load unit, debug port, …) using round-robin arbitration and a valid/grant handshake. It also sequences a bulk clear that zeroes every writable register. It sits directly in front of the register file write port and is the only driver of the write enable, write address and write data. Register 0 is hardwired to zero and is never written.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 6, register address width; the file holds 2^ADDR_W entries
- DATA_W, 32, data width

- clk  in  1  clock; everything updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester write request; bit i belongs to requester i
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot grant, combinational; a transfer occurs at any rising edge where req[i] & gnt[i] = 1
- clear_req  in  1  starts the bulk clear; sampled in IDLE only
- clear_busy  out  1  high while the clear sequence runs
- clear_done  out  1  one-cycle pulse that marks the final clear write
- wr_en  out  1  registered write enable to the register file
- wr_addr  out  ADDR_W  registered write address
- wr_data  out  DATA_W  registered write data

## Operation
- States: IDLE and CLEAR.
- Reset (rst=0, asynchronous):
  - state = IDLE
  - round-robin pointer = 0
  - wr_en, wr_addr, wr_data, clear_busy, clear_done = 0
  - gnt = 0 while rst is low
- IDLE arbitration:
  - The winner is the first requester with req high, scanning from pointer upward with wrap.
  - gnt is one-hot to the winner, or all-zero if no request is pending.
  - After a transfer from requester k, pointer becomes (k+1) mod NUM_REQ. The pointer is unchanged if no transfer occurs.
- Handshake:
  - A requester holds req, req_addr and req_data stable until it sees gnt at a rising edge.
  - It may keep req high to issue back-to-back writes; round-robin still applies.
  - gnt never depends on req_addr or req_data.
- Write issue:
  - A transfer at edge E sets wr_addr and wr_data to the winner's values at E.
  - wr_en is set to 1 at E unless the address is 0. An address-0 transfer is consumed: gnt is given and the pointer advances, but wr_en = 0.
  - With no transfer at E, wr_en = 0. wr_addr and wr_data hold their previous values.
- Clear start: clear_req high at an IDLE edge E0:
  - Go to CLEAR with counter = 1.
  - gnt is forced to 0 combinationally in the cycle before E0 whenever clear_req=1, so clear takes priority over a simultaneous request.
  - No transfer occurs at E0.
- CLEAR sequence:
  - gnt = 0 throughout.
  - At each edge: wr_en = 1, wr_addr = counter, wr_data = 0, counter increments.
  - Total of 2^ADDR_W − 1 writes, covering addresses 1 to all-ones.
  - clear_busy = 1 in every clear write cycle.
  - clear_done = 1 only in the cycle where wr_addr = all-ones.
  - The state returns to IDLE at the edge that ends that cycle, and arbitration resumes at that same edge.
- clear_req while in CLEAR is ignored and never queued.
- Reset during CLEAR aborts the sequence. No clear_done pulse is produced.

## Timing
- Grant is zero-latency: gnt responds combinationally to req within the same cycle.
- Write latency is 1 cycle: a transfer at edge E gives wr_en/wr_addr/wr_data valid in the cycle following E.
- Throughput is one write per cycle in aggregate. A single requester can sustain one write per cycle when it is the only requester.
- Under full contention each of NUM_REQ requesters receives exactly 1 of every NUM_REQ grants.
- Clear timing:
  - clear_busy rises 1 cycle after clear_req is sampled.
  - Duration is 2^ADDR_W − 1 cycles (63 with defaults).
  - The first IDLE grant is possible at the edge ending the clear_done cycle.

## Test plan
- Reset → all outputs 0. Then req=0001, addr0=5, data0=0xDEADBEEF → gnt=0001; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
- req=1111 held for 8 cycles, pointer initially 0 → grant order 0,1,2,3,0,1,2,3, each with a one-cycle wr_en pulse carrying that requester's data.
- req=0100, addr2=0 → gnt=0100, pointer advances to 3, wr_en stays 0 next cycle.
- clear_req=1 together with req=0011 → gnt=0000 that cycle. Then 63 writes of 0 to addresses 1..63, clear_busy high for 63 cycles, clear_done only at wr_addr=63. After that, requester 0 is granted (pointer unchanged at 0).
- clear_req pulsed again during CLEAR → no restart; sequence length remains 63.
- rst low at clear write address 20 → all outputs 0 immediately, state IDLE, no clear_done. After release, req=0010 → gnt=0010.
